arm_mc_controller: RTL
======================

ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max consecutive mem_ready-low cycles in one memory state before fault.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports Instruction in 32 (latched instruction word), ALUFlags in 4 (NZCV from ALU) and mem_ready in 1 (memory access completes this cycle).
REQ-005 SHALL have outputs RegSource 2, RegWrite 1, ImmediateSource 2, ALUSrc 1, ALUControl 2, MemtoReg 1 and PCSource 1, matching the datapath control inputs.
REQ-006 SHALL have outputs IRWrite 1 (instruction latch enable), PCWrite 1 (PC enable), MemRead 1, MemWrite 1, fault 1 (sticky) and flags_q 4 (stored NZCV).

Function
REQ-007 SHALL be a Moore FSM with states START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT; outputs decode from the state register and Instruction only.
REQ-008 SHALL drive all outputs 0 in START and FAULT; START always goes to FETCH next cycle.
REQ-009 FETCH SHALL assert MemRead; on mem_ready=1 it SHALL assert IRWrite and PCWrite with PCSource=0 and go to DECODE; otherwise it stays.
REQ-010 DECODE SHALL set RegSource={op==01, op==10} with op=Instruction[27:26].
- Condition false: go to FETCH with no write enables.
- Condition true: op 00 with I=0 -> EXECR; op 00 with I=1 -> EXECI; op 01 -> MEMADR; op 10 -> BRANCH; op 11 -> FETCH as a no-op.
REQ-011 ALUControl SHALL map cmd=Instruction[24:21] as follows: 0100->00 ADD, 0010->01 SUB, 1010 CMP->01, 0000->10 AND, 1100->11 ORR; any other cmd is a no-op returning to FETCH.
REQ-012 EXECR SHALL set ALUSrc=0; EXECI SHALL set ALUSrc=1 and ImmediateSource=00; both go to ALUWB.
REQ-013 ALUWB SHALL assert RegWrite with MemtoReg=0 unless cmd=CMP, then go to FETCH.
REQ-014 MEMADR SHALL set ALUSrc=1, ImmediateSource=01 and ALUControl=00; it goes to MEMRD if L=Instruction[20]=1, else MEMWR.
REQ-015 MEMRD and MEMWR SHALL assert MemRead and MemWrite respectively and hold until mem_ready=1.
- MEMRD then goes to MEMWB.
- MEMWR then goes to FETCH.
REQ-016 MEMWB SHALL assert RegWrite with MemtoReg=1, then go to FETCH.
REQ-017 BRANCH SHALL set ImmediateSource=10, ALUSrc=1, ALUControl=00, PCSource=1 and PCWrite=1, then go to FETCH.
REQ-018 Instruction latency SHALL be, with mem_ready always 1: data-processing 4 cycles, LDR 5, STR 4, B 3, condition-failed 2.
REQ-019 flags_q SHALL load ALUFlags at the end of ALUWB when S=Instruction[20]=1 and op=00, CMP included; it is otherwise held.
REQ-020 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle mem_ready=0 in those states.
- Reaching WAIT_MAX goes to FAULT and sets fault=1.
- FAULT is left only by reset.
REQ-021 mem_ready=1 in the same cycle the counter reaches WAIT_MAX SHALL complete the access rather than fault.

Reset
REQ-022 rst=0 SHALL immediately force state START, flags_q=0, wait counter 0 and fault=0, regardless of the current state or a pending access.
REQ-023 After rst deasserts, the first FETCH SHALL occur on the second rising edge.

Configuration
REQ-024 With ARM_COND_EXEC_EN defined, DECODE SHALL evaluate Instruction[31:28] against flags_q for all 15 ARM conditions (EQ..LE, AL); 1111 is treated as false.
REQ-025 Without ARM_COND_EXEC_EN, every instruction SHALL execute unconditionally, the flags_q register SHALL be absent, and flags_q SHALL read 0.

Structure
REQ-026 Package arm_ctrl_pkg SHALL hold the state enum, the ALUControl and ImmediateSource encodings, the op and cmd constants, and the condition-code constants.
REQ-027 The condition evaluator SHALL be sub-module arm_cond_check (cond, flags -> pass), instantiated only under ARM_COND_EXEC_EN.

Verification
REQ-028 0xE0821003 (ADD R1,R2,R3), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=00.
REQ-029 0xE1520003 (CMP R2,R3) with ALUFlags=0100 -> no RegWrite; flags_q=0100 after ALUWB.
REQ-030 0x0A000002 (BEQ): with flags_q Z=1 -> BRANCH with PCSource=1 and PCWrite=1; with Z=0 -> DECODE then FETCH with no PCWrite.
REQ-031 0xE5921004 (LDR) with mem_ready low 3 cycles in MEMRD -> MEMRD lasts 4 cycles, then MEMWB with RegWrite=1 and MemtoReg=1.
REQ-032 mem_ready held 0 in MEMWR with WAIT_MAX=15 -> fault=1 after 15 wait cycles; only rst=0 clears it.
REQ-033 rst=0 asserted mid-MEMWR -> MemWrite drops immediately, state START, flags_q=0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// arm_ctrl_pkg : shared encodings for the ARM multicycle control unit
// Revision     : 1.0
// ============================================================================
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_FAULT  = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP     = 2'b00;
    localparam logic [1:0] IMM_MEM    = 2'b01;
    localparam logic [1:0] IMM_BRANCH = 2'b10;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] ctl;
        case (cmd)
            CMD_SUB, CMD_CMP: ctl = ALU_SUB;
            CMD_AND:          ctl = ALU_AND;
            CMD_ORR:          ctl = ALU_ORR;
            default:          ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_cond_check.sv
`default_nettype none
// ============================================================================
// arm_cond_check : evaluates an ARM condition field against stored NZCV flags
// Revision       : 1.0
// ============================================================================
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = !w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = !w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = !w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = !w_v;
            COND_HI: pass = w_c && !w_z;
            COND_LS: pass = !w_c || w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = !w_z && (w_n == w_v);
            COND_LE: pass = w_z || (w_n != w_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // 1111 is reserved and never executes
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arm_mc_controller.sv
`default_nettype none
// ============================================================================
// arm_mc_controller : multicycle ARM control FSM with memory wait timeout
// Option ARM_COND_EXEC_EN adds conditional execution and the flags_q register.
// Revision          : 1.0
// ============================================================================
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic [1:0]  RegSource,
    output logic        RegWrite,
    output logic [1:0]  ImmediateSource,
    output logic        ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        MemtoReg,
    output logic        PCSource,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        fault,
    output logic [3:0]  flags_q
);

    localparam int c_wait_w = $clog2(WAIT_MAX + 1);

    state_t              r_state, w_state_next;
    logic [c_wait_w-1:0] r_wait;
    logic [1:0]          w_op;
    logic [3:0]          w_cmd;
    logic                w_cond_pass;
    logic                w_in_wait_state;
    logic                w_wait_expired;
    logic                w_unused;

    assign w_op  = Instruction[27:26];
    assign w_cmd = Instruction[24:21];

`ifdef ARM_COND_EXEC_EN
    logic [3:0] r_flags;

    arm_cond_check u_cond_check (
        .cond  (Instruction[31:28]),
        .flags (r_flags),
        .pass  (w_cond_pass)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= 4'b0;
        end else if (r_state == S_ALUWB && Instruction[20] && w_op == OP_DP) begin
            r_flags <= ALUFlags;
        end
    end

    assign flags_q  = r_flags;
    assign w_unused = ^Instruction[19:0];
`else
    assign w_cond_pass = 1'b1;
    assign flags_q     = 4'b0;
    assign w_unused    = ^{Instruction[31:28], Instruction[19:0], ALUFlags};
`endif

    assign w_in_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                             (r_state == S_MEMWR);
    // The cycle that would push the count to WAIT_MAX faults only if memory is still not ready.
    assign w_wait_expired  = !mem_ready && (r_wait == c_wait_w'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (w_state_next != r_state) begin
            r_wait <= '0;
        end else if (w_in_wait_state && !mem_ready) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else if (w_state_next == S_FAULT) begin
            fault <= 1'b1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        RegSource       = 2'b00;
        RegWrite        = 1'b0;
        ImmediateSource = IMM_DP;
        ALUSrc          = 1'b0;
        ALUControl      = ALU_ADD;
        MemtoReg        = 1'b0;
        PCSource        = 1'b0;
        IRWrite         = 1'b0;
        PCWrite         = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;

        case (r_state)
            S_START: w_state_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_wait_expired) begin
                    w_state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                RegSource = {w_op == OP_MEM, w_op == OP_BRANCH};
                if (!w_cond_pass) begin
                    w_state_next = S_FETCH;
                end else begin
                    case (w_op)
                        OP_DP: begin
                            if (!cmd_supported(w_cmd))  w_state_next = S_FETCH;
                            else if (Instruction[25])   w_state_next = S_EXECI;
                            else                        w_state_next = S_EXECR;
                        end
                        OP_MEM:    w_state_next = S_MEMADR;
                        OP_BRANCH: w_state_next = S_BRANCH;
                        default:   w_state_next = S_FETCH;
                    endcase
                end
            end
            S_EXECR: begin
                ALUControl   = alu_decode(w_cmd);
                w_state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrc       = 1'b1;
                ALUControl   = alu_decode(w_cmd);
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = (w_cmd != CMD_CMP);
                w_state_next = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrc          = 1'b1;
                ImmediateSource = IMM_MEM;
                w_state_next    = Instruction[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                if (mem_ready)           w_state_next = S_MEMWB;
                else if (w_wait_expired) w_state_next = S_FAULT;
            end
            S_MEMWB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                if (mem_ready)           w_state_next = S_FETCH;
                else if (w_wait_expired) w_state_next = S_FAULT;
            end
            S_BRANCH: begin
                ImmediateSource = IMM_BRANCH;
                ALUSrc          = 1'b1;
                PCSource        = 1'b1;
                PCWrite         = 1'b1;
                w_state_next    = S_FETCH;
            end
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_START;
        endcase
    end

endmodule
`default_nettype wire
